// File: rtl/capture_pkg.sv
// capture_pkg: shared FSM states, opcodes and abort byte for capture_ctrl.
// The STATUS state exists only when CAPTURE_CTRL_STATUS_EN is defined.
package capture_pkg;
`ifdef CAPTURE_CTRL_STATUS_EN
  typedef enum logic [2:0] {IDLE, CMD1, CAPTURE, DRAIN, STATUS} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD1, CAPTURE, DRAIN} state_t;
`endif
  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_ARM  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
endpackage

// File: rtl/capture_ctrl_tx_pacer.sv
// tx_pacer: guarded one-byte-at-a-time handshake to the UART transmitter.
module tx_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       busy,
  input  logic       pop_en,
  input  logic [7:0] din,
  output logic       guard,
  output logic       tx_start,
  output logic       fifo_rd,
  output logic [7:0] tx_dat
);
  logic       fire, guard_d, tx_start_d, fifo_rd_d;
  logic [7:0] tx_dat_d;
  // guard masks the cycle between tx_start and tx_busy rising
  always_comb begin
    fire       = req && !busy && !guard;
    guard_d    = fire;
    tx_start_d = fire;
    fifo_rd_d  = fire && pop_en;
    tx_dat_d   = fire ? din : tx_dat;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      guard    <= 1'b0;
      tx_start <= 1'b0;
      fifo_rd  <= 1'b0;
      tx_dat   <= 8'h00;
    end else begin
      guard    <= guard_d;
      tx_start <= tx_start_d;
      fifo_rd  <= fifo_rd_d;
      tx_dat   <= tx_dat_d;
    end
  end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: UART-commanded sample capture, drain and register write controller.
// Define CAPTURE_CTRL_STATUS_EN to add the STATUS query (opcode 11).
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int TIMEOUT_CYC = 480000,
  parameter int LEN_MAX     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_stb,
  input  logic [7:0] rx_dat,
  input  logic       sample_stb,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic [7:0] fifo_dout,
  input  logic       tx_busy,
  output logic       cap_en,
  output logic       fifo_rd,
  output logic       fifo_clr,
  output logic       tx_start,
  output logic [7:0] tx_dat,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       overflow
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LEN_MAX + 1);
  state_t          state_q, state_d;
  logic [5:0]      cmd_q, cmd_d;
  logic            reg_we_q, reg_we_d, overflow_q, overflow_d;
  logic [3:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [LW-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic            abort, clr, last, req, guard;
  logic [7:0]      tx_din;
`ifdef CAPTURE_CTRL_STATUS_EN
  logic            sent_q, sent_d;
  assign tx_din = state_q == STATUS ? {1'b1, overflow_q, 1'b0, fifo_full, fifo_empty, 3'b000} : fifo_dout;
  assign req    = rst && !abort && (state_q == DRAIN ? !fifo_empty : state_q == STATUS && !sent_q && !tx_start);
`else
  assign tx_din = fifo_dout;
  assign req    = rst && !abort && state_q == DRAIN && !fifo_empty;
`endif
  // CMD1 takes 0xFF as data; everywhere else it aborts
  assign abort     = rx_stb && rx_dat == ABORT_BYTE && state_q != CMD1;
  assign cap_en    = rst && state_q == CAPTURE && !abort;
  assign fifo_clr  = rst && clr;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign overflow  = overflow_q;
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    overflow_d  = overflow_q;
    tmo_d       = tmo_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    clr         = 1'b0;
    last        = sample_stb && cnt_q + LW'(1) == len_q;
`ifdef CAPTURE_CTRL_STATUS_EN
    sent_d      = sent_q || tx_start;
`endif
    case (state_q)
      IDLE: if (rx_stb) begin
        cmd_d   = {rx_dat[7:6], rx_dat[3:0]};
        tmo_d   = '0;
        state_d = CMD1;
      end
      CMD1: if (rx_stb) begin
        state_d = IDLE;
        case (cmd_q[5:4])
          OP_REG: begin
            reg_we_d    = 1'b1;
            reg_addr_d  = cmd_q[3:0];
            reg_wdata_d = rx_dat;
          end
          OP_ARM: begin
            clr        = 1'b1;
            overflow_d = 1'b0;
            len_d      = LW'(rx_dat) + LW'(1);
            cnt_d      = '0;
            state_d    = CAPTURE;
          end
`ifdef CAPTURE_CTRL_STATUS_EN
          OP_STAT: begin
            sent_d  = 1'b0;
            state_d = STATUS;
          end
`endif
          default: ;
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      CAPTURE: begin
        cnt_d = sample_stb ? cnt_q + LW'(1) : cnt_q;
        // reaching the length wins over a simultaneous fifo_full
        state_d    = last || fifo_full ? DRAIN : CAPTURE;
        overflow_d = overflow_q || (fifo_full && !last);
      end
      DRAIN: state_d = fifo_empty && !tx_busy && !guard ? IDLE : DRAIN;
`ifdef CAPTURE_CTRL_STATUS_EN
      STATUS: state_d = sent_q && !tx_busy && !guard ? IDLE : STATUS;
`endif
      default: state_d = IDLE;
    endcase
    if (abort) begin
      clr     = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      overflow_q  <= 1'b0;
      tmo_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
`ifdef CAPTURE_CTRL_STATUS_EN
      sent_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      overflow_q  <= overflow_d;
      tmo_q       <= tmo_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
`ifdef CAPTURE_CTRL_STATUS_EN
      sent_q      <= sent_d;
`endif
    end
  end
  tx_pacer u_pacer (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .busy     (tx_busy),
    .pop_en   (state_q == DRAIN),
    .din      (tx_din),
    .guard    (guard),
    .tx_start (tx_start),
    .fifo_rd  (fifo_rd),
    .tx_dat   (tx_dat)
  );
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench with a 16-deep FWFT FIFO and a 3-cycle UART busy model.
module tb_capture_ctrl;
  import capture_pkg::*;
  localparam int TMO = 20;
  logic       clk, rst, rx_stb, sample_stb, fifo_empty, fifo_full, tx_busy;
  logic [7:0] rx_dat, sample_dat, fifo_dout, tx_dat, reg_wdata;
  logic       cap_en, fifo_rd, fifo_clr, tx_start, reg_we, overflow;
  logic [3:0] reg_addr;
  int n_chk = 0, n_fail = 0, n_clr = 0, n_we = 0, n_chg = 0;
  logic [7:0] txlog[$];
  logic [7:0] busy_dat;

  capture_ctrl #(.TIMEOUT_CYC(TMO), .LEN_MAX(256)) dut (
    .clk(clk), .rst(rst), .rx_stb(rx_stb), .rx_dat(rx_dat), .sample_stb(sample_stb),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout), .tx_busy(tx_busy),
    .cap_en(cap_en), .fifo_rd(fifo_rd), .fifo_clr(fifo_clr), .tx_start(tx_start), .tx_dat(tx_dat),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  logic [1:0] bcnt;
  wire fwr = sample_stb && cap_en && !fifo_full;
  wire frd = fifo_rd && !fifo_empty;
  assign fifo_empty = fcnt == 5'd0;
  assign fifo_full  = fcnt == 5'd16;
  assign fifo_dout  = mem[rp];
  assign tx_busy    = bcnt != 2'd0;
  always @(posedge clk) begin
    if (!rst || fifo_clr) begin
      wp <= 4'd0; rp <= 4'd0; fcnt <= 5'd0;
    end else begin
      if (fwr) begin mem[wp] <= sample_dat; wp <= wp + 4'd1; end
      if (frd) rp <= rp + 4'd1;
      fcnt <= fcnt + 5'(fwr) - 5'(frd);
    end
    if (!rst) bcnt <= 2'd0;
    else if (tx_start) bcnt <= 2'd3;
    else if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
  end

  always @(negedge clk) begin
    if (tx_start) begin txlog.push_back(tx_dat); busy_dat = tx_dat; end
    else if (tx_busy && tx_dat !== busy_dat) n_chg++;
    if (reg_we) n_we++;
    if (fifo_clr) n_clr++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_stb = 1'b1; rx_dat = b;
    tick();
    rx_stb = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && dut.state_q !== IDLE; i++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; rx_stb = 1'b1; rx_dat = 8'hFF; sample_stb = 1'b0; sample_dat = 8'h00;
    tick(3);
    n_chk++; if ({cap_en, fifo_rd, fifo_clr, tx_start, reg_we, overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 000000", {cap_en, fifo_rd, fifo_clr, tx_start, reg_we, overflow}); end
    n_chk++; if ({tx_dat, reg_addr, reg_wdata} !== 20'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000", {tx_dat, reg_addr, reg_wdata}); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    n_chk++; if (n_clr !== 0) begin n_fail++; $display("FAIL reset_no_clr: got %0d expected 0", n_clr); end
    rx_stb = 1'b0; rx_dat = 8'h00; rst = 1'b1;
    tick(2);
  endtask

  task automatic test_reg_write;
    int w0 = n_we;
    send_byte(8'h05); send_byte(8'h3C);
    n_chk++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL reg_we_pulse: got %b expected 1", reg_we); end
    n_chk++; if ({reg_addr, reg_wdata} !== 12'h53C) begin n_fail++; $display("FAIL reg_addr_data: got %h expected 53c", {reg_addr, reg_wdata}); end
    tick();
    n_chk++; if (n_we - w0 !== 1) begin n_fail++; $display("FAIL reg_we_count: got %0d expected 1", n_we - w0); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reg_state: got %0d expected IDLE", dut.state_q); end
    send_byte(8'h07); send_byte(8'hFF);
    n_chk++; if ({reg_we, reg_addr, reg_wdata} !== 13'h17FF) begin
      n_fail++; $display("FAIL reg_ff_data: got %h expected 17ff", {reg_we, reg_addr, reg_wdata}); end
    tick(2);
  endtask

  task automatic test_timeout;
    int w0 = n_we;
    send_byte(8'h05);
    tick(TMO - 1);
    n_chk++; if (dut.state_q !== CMD1) begin n_fail++; $display("FAIL tmo_edge: got %0d expected CMD1", dut.state_q); end
    tick();
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL tmo_idle: got %0d expected IDLE", dut.state_q); end
    n_chk++; if (n_we - w0 !== 0) begin n_fail++; $display("FAIL tmo_no_we: got %0d expected 0", n_we - w0); end
    send_byte(8'h06); send_byte(8'h01);
    n_chk++; if ({reg_we, reg_addr, reg_wdata} !== 13'h1601) begin
      n_fail++; $display("FAIL tmo_next_write: got %h expected 1601", {reg_we, reg_addr, reg_wdata}); end
    tick(2);
  endtask

  task automatic test_capture;
    logic [7:0] pat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int t0 = txlog.size();
    int c0 = n_clr;
    send_byte(8'h40); send_byte(8'h03);
    n_chk++; if (n_clr - c0 !== 1) begin n_fail++; $display("FAIL cap_arm_clr: got %0d expected 1", n_clr - c0); end
    n_chk++; if (cap_en !== 1'b1) begin n_fail++; $display("FAIL cap_en_on: got %b expected 1", cap_en); end
    for (int i = 0; i < 4; i++) begin sample_stb = 1'b1; sample_dat = pat[i]; tick(); end
    sample_stb = 1'b0; #1;
    n_chk++; if (cap_en !== 1'b0) begin n_fail++; $display("FAIL cap_en_off: got %b expected 0", cap_en); end
    wait_idle(300);
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL cap_drain_done: got %0d expected IDLE", dut.state_q); end
    n_chk++; if (txlog.size() - t0 !== 4) begin n_fail++; $display("FAIL cap_tx_count: got %0d expected 4", txlog.size() - t0); end
    for (int i = 0; i < 4 && t0 + i < txlog.size(); i++) begin
      n_chk++; if (txlog[t0 + i] !== pat[i]) begin n_fail++; $display("FAIL cap_tx_byte%0d: got %h expected %h", i, txlog[t0 + i], pat[i]); end
    end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL cap_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_full_at_last;
    int t0 = txlog.size();
    send_byte(8'h40); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin sample_stb = 1'b1; sample_dat = 8'h20 + 8'(i); tick(); end
    n_chk++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fal_full: got %b expected 1", fifo_full); end
    sample_dat = 8'h30; tick();
    sample_stb = 1'b0;
    n_chk++; if ({dut.state_q == DRAIN, overflow} !== 2'b10) begin
      n_fail++; $display("FAIL fal_drain_noovf: got %b expected 10", {dut.state_q == DRAIN, overflow}); end
    wait_idle(300);
    n_chk++; if (txlog.size() - t0 !== 16) begin n_fail++; $display("FAIL fal_tx_count: got %0d expected 16", txlog.size() - t0); end
  endtask

  task automatic test_overflow;
    int t0 = txlog.size();
    send_byte(8'h40); send_byte(8'hFF);
    for (int i = 0; i < 16; i++) begin sample_stb = 1'b1; sample_dat = 8'(i); tick(); end
    n_chk++; if ({dut.state_q == CAPTURE, overflow} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_pre: got %b expected 10", {dut.state_q == CAPTURE, overflow}); end
    sample_dat = 8'h10; tick();
    sample_stb = 1'b0;
    n_chk++; if ({dut.state_q == DRAIN, overflow, cap_en} !== 3'b110) begin
      n_fail++; $display("FAIL ovf_drain: got %b expected 110", {dut.state_q == DRAIN, overflow, cap_en}); end
    wait_idle(300);
    n_chk++; if (txlog.size() - t0 !== 16) begin n_fail++; $display("FAIL ovf_tx_count: got %0d expected 16", txlog.size() - t0); end
    for (int i = 0; i < 16 && t0 + i < txlog.size(); i += 5) begin
      n_chk++; if (txlog[t0 + i] !== 8'(i)) begin n_fail++; $display("FAIL ovf_tx_byte%0d: got %h expected %h", i, txlog[t0 + i], 8'(i)); end
    end
  endtask

  task automatic test_status;
    int t0 = txlog.size();
    send_byte(8'hC0); send_byte(8'h00);
`ifdef CAPTURE_CTRL_STATUS_EN
    for (int i = 0; i < 50 && txlog.size() == t0; i++) tick();
    wait_idle(50);
    tick(5);
    n_chk++; if (txlog.size() - t0 !== 1) begin n_fail++; $display("FAIL stat_count: got %0d expected 1", txlog.size() - t0); end
    n_chk++; if (txlog.size() > t0 && txlog[t0] !== 8'hC8) begin n_fail++; $display("FAIL stat_byte: got %h expected c8", txlog[t0]); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL stat_idle: got %0d expected IDLE", dut.state_q); end
`else
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL stat_nop_idle: got %0d expected IDLE", dut.state_q); end
    tick(10);
    n_chk++; if (txlog.size() - t0 !== 0) begin n_fail++; $display("FAIL stat_nop_tx: got %0d expected 0", txlog.size() - t0); end
`endif
  endtask

  task automatic test_abort;
    int t0 = txlog.size();
    int c0 = n_clr;
    int g0 = n_chg;
    send_byte(8'h40); send_byte(8'h03);
    for (int i = 0; i < 4; i++) begin sample_stb = 1'b1; sample_dat = 8'h11 + 8'(i); tick(); end
    sample_stb = 1'b0;
    for (int i = 0; i < 50 && tx_busy !== 1'b1; i++) tick();
    n_chk++; if ({tx_busy, dut.state_q == DRAIN} !== 2'b11) begin
      n_fail++; $display("FAIL abort_setup: got %b expected 11", {tx_busy, dut.state_q == DRAIN}); end
    rx_stb = 1'b1; rx_dat = 8'hFF; #1;
    n_chk++; if (fifo_clr !== 1'b1) begin n_fail++; $display("FAIL abort_clr: got %b expected 1", fifo_clr); end
    tick();
    rx_stb = 1'b0;
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected IDLE", dut.state_q); end
    tick(10);
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_inflight_done: got %b expected 0", tx_busy); end
    n_chk++; if (txlog.size() - t0 !== 1) begin n_fail++; $display("FAIL abort_tx_count: got %0d expected 1", txlog.size() - t0); end
    n_chk++; if (txlog.size() > t0 && txlog[t0] !== 8'h11) begin n_fail++; $display("FAIL abort_tx_byte: got %h expected 11", txlog[t0]); end
    n_chk++; if (n_chg - g0 !== 0) begin n_fail++; $display("FAIL abort_tx_dat_stable: got %0d changes expected 0", n_chg - g0); end
    n_chk++; if (n_clr - c0 !== 2) begin n_fail++; $display("FAIL abort_clr_count: got %0d expected 2", n_clr - c0); end
    send_byte(8'hFF);
    n_chk++; if ({dut.state_q == IDLE, n_clr - c0 == 3} !== 2'b11) begin
      n_fail++; $display("FAIL abort_idle_ff: got %b expected 11", {dut.state_q == IDLE, n_clr - c0 == 3}); end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_timeout();
    test_capture();
    test_full_at_last();
    test_overflow();
    test_status();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 480000, max clk cycles allowed between the two bytes of a command.
REQ-002 SHALL have parameter LEN_MAX, default 256, largest capture length in samples.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-low reset.
REQ-005 SHALL have port rx_stb  in  1  one-cycle strobe: rx_dat holds a received UART byte.
REQ-006 SHALL have port rx_dat  in  8  received UART byte.
REQ-007 SHALL have port sample_stb  in  1  one-cycle strobe: the sample source has a new byte.
REQ-008 SHALL have port fifo_empty  in  1  capture FIFO empty.
REQ-009 SHALL have port fifo_full  in  1  capture FIFO full.
REQ-010 SHALL have port fifo_dout  in  8  FIFO head byte, valid while !fifo_empty (first-word-fall-through).
REQ-011 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-012 SHALL have port cap_en  out  1  FIFO write enable; the FIFO writes on sample_stb && cap_en.
REQ-013 SHALL have port fifo_rd  out  1  one-cycle pop of the FIFO head.
REQ-014 SHALL have port fifo_clr  out  1  one-cycle FIFO flush.
REQ-015 SHALL have port tx_start  out  1  one-cycle UART transmit trigger.
REQ-016 SHALL have port tx_dat  out  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-017 SHALL have port reg_we  out  1  one-cycle register write strobe.
REQ-018 SHALL have port reg_addr  out  4  register write address.
REQ-019 SHALL have port reg_wdata  out  8  register write data.
REQ-020 SHALL have port overflow  out  1  sticky flag: the FIFO filled before the capture length was reached.

Function
REQ-021 SHALL implement the FSM states IDLE, CMD1, CAPTURE, DRAIN and STATUS.
REQ-022 SHALL, in IDLE on rx_stb, latch rx_dat as byte0 and go to CMD1, except when rx_dat is 0xFF.
REQ-023 SHALL, in CMD1 on rx_stb, decode byte0[7:6] with rx_dat as byte1: 00 = register write, 01 = arm, 10 = no-op, 11 = status query.
REQ-024 SHALL, on register write, pulse reg_we one cycle after the byte1 strobe, with reg_addr=byte0[3:0] and reg_wdata=byte1, then return to IDLE.
REQ-025 SHALL, on arm, pulse fifo_clr, clear overflow, load the length register with byte1+1 (range 1..256), and enter CAPTURE on the next cycle.
REQ-026 SHALL return from CMD1 to IDLE with no action if TIMEOUT_CYC cycles pass without rx_stb.
REQ-027 SHALL hold cap_en high only while in CAPTURE.
REQ-028 SHALL, in CAPTURE, count sample_stb and go to DRAIN in the cycle the count reaches the length.
REQ-029 SHALL, in CAPTURE, go to DRAIN and set overflow when fifo_full rises before the count reaches the length.
REQ-030 SHALL treat fifo_full and the final count in the same cycle as a normal completion, leaving overflow at 0.
REQ-031 SHALL, in DRAIN, when !fifo_empty, !tx_busy and the guard is clear: latch tx_dat=fifo_dout, pulse fifo_rd and tx_start together, and set the guard.
REQ-032 SHALL clear the guard one cycle after it is set, covering the one-cycle lag before tx_busy rises.
REQ-033 SHALL go from DRAIN to IDLE when fifo_empty and !tx_busy.
REQ-034 SHALL, in STATUS, send the byte {1, overflow, 0, fifo_full, fifo_empty, 3'b000} once using the same handshake and guard as DRAIN, then return to IDLE.
REQ-035 SHALL treat rx_dat 0xFF on rx_stb in IDLE, CAPTURE, DRAIN or STATUS as abort: drop cap_en, pulse fifo_clr, and go to IDLE next cycle.
REQ-036 SHALL let a tx_start already issued complete untouched when an abort arrives.
REQ-037 SHALL treat 0xFF received in CMD1 as byte1 data, not as an abort.
REQ-038 SHALL ignore rx_stb in CAPTURE, DRAIN and STATUS except for the 0xFF abort.

Reset
REQ-039 SHALL, while rst=0 at a clock edge, force state IDLE and drive cap_en, fifo_rd, fifo_clr, tx_start, reg_we and overflow to 0, with tx_dat, reg_addr, reg_wdata, the counters and the guard all 0.
REQ-040 SHALL, on reset mid-capture or mid-drain, abandon the operation with no fifo_clr pulse; the FIFO shares the same reset.

Configuration
REQ-041 SHALL, with CAPTURE_CTRL_STATUS_EN defined, implement the STATUS state and opcode 11.
REQ-042 SHALL, with CAPTURE_CTRL_STATUS_EN undefined, treat opcode 11 as a no-op, omit the STATUS state, and never produce a tx_start outside DRAIN.

Structure
REQ-043 SHALL place the state enum, the opcode constants and the ABORT_BYTE=8'hFF constant in the shared package capture_pkg.
REQ-044 SHALL implement the guarded tx_start/fifo_rd handshake as the sub-module tx_pacer, instantiated once.

Verification
REQ-045 SHALL check register write: rx 0x05 then 0x3C -> one reg_we pulse with reg_addr=5 and reg_wdata=0x3C, state IDLE.
REQ-046 SHALL check capture: rx 0x40 then 0x03, then 4 sample_stb -> cap_en drops after the 4th; 4 tx_start pulses carry the FIFO bytes in order; overflow=0.
REQ-047 SHALL check overflow: arm with length 256 against a 16-deep FIFO -> DRAIN entered on fifo_full with overflow=1; 16 bytes transmitted.
REQ-048 SHALL check timeout: rx 0x05, then no byte for TIMEOUT_CYC cycles -> IDLE with no reg_we; a following 0x06, 0x01 pair writes addr 6.
REQ-049 SHALL check abort: send 0xFF mid-DRAIN with tx_busy=1 -> fifo_clr pulses, IDLE next cycle, the in-flight byte completes, no further tx_start.
REQ-050 SHALL check status (macro defined): after an overflow capture, rx 0xC0 then 0x00 -> one tx_start with tx_dat=0xC8 (empty FIFO).
